// File: rtl/uart_out_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: state encodings,
// frame constants and the bit-period rounding helper used by both link ends.
package uart_out_buffered_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] UART_TX_IDLE  = 2'd0;
  localparam logic [1:0] UART_TX_START = 2'd1;
  localparam logic [1:0] UART_TX_DATA  = 2'd2;
  localparam logic [1:0] UART_TX_STOP  = 2'd3;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int bit_period(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_out_fifo.sv
// Single-clock FIFO with registered occupancy; the head entry is readable
// in the same cycle that empty is low.
module uart_out_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [Width-1:0]       data_in,
  input  logic                   pop,
  output logic [Width-1:0]       data_out,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CountFull);
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];

  // NOTE: storage carries no reset; the count gates every read, so stale
  // contents are never observed and the array maps onto plain RAM/regs.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // NOTE: all state updates are non-blocking so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_out_buffered.sv
// Buffered 8N1/8N2 UART transmitter: bytes enter a FIFO on a valid/ready
// handshake and leave LSB first on uart_tx with no gap between frames.
module uart_out_buffered
  import uart_out_buffered_pkg::*;
#(
  parameter int ClockFrequency = 12000000,
  parameter int BaudRate       = 9600,
  parameter int FifoDepth      = 4,
  parameter int StopBits       = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [$clog2(FifoDepth):0] fifo_count
);

  localparam int BitCount  = bit_period(ClockFrequency, BaudRate);
  localparam int StopCount = StopBits * BitCount;
  localparam int CntW      = $clog2(StopCount);
  localparam logic [CntW-1:0] BitReload  = CntW'(BitCount - 1);
  localparam logic [CntW-1:0] StopReload = CntW'(StopCount - 1);
  localparam logic [2:0]      LastIdx    = 3'(DATA_BITS - 1);

  if (BitCount < 2) begin : g_bad_count
    $error("uart_out_buffered: bit period below 2 clocks");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_out_buffered: FifoDepth must be a power of two >= 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
    $error("uart_out_buffered: StopBits must be 1 or 2");
  end

  logic [1:0]           state;
  logic [CntW-1:0]      bit_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shifter;
  logic                 bit_end;
  logic                 ready_en;
  logic                 push;
  logic                 pop;
  logic [7:0]           fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_out_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .data_in  (in_data),
    .pop      (pop),
    .data_out (fifo_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Holds in_ready low through reset and the first cycle after release.
  always_ff @(posedge clock) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign in_ready = ready_en && !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (bit_cnt == '0);
  assign pop      = !fifo_empty &&
                    ((state == UART_TX_IDLE) || (state == UART_TX_STOP && bit_end));
  assign busy     = (state != UART_TX_IDLE) || (fifo_count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= UART_TX_IDLE;
      uart_tx <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
    end else begin
      case (state)
        UART_TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            shifter <= fifo_data;
            uart_tx <= 1'b0;
            bit_cnt <= BitReload;
            state   <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (bit_end) begin
            uart_tx <= shifter[0];
            bit_idx <= '0;
            bit_cnt <= BitReload;
            state   <= UART_TX_DATA;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        UART_TX_DATA: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (bit_idx == LastIdx) begin
            uart_tx <= 1'b1;
            bit_cnt <= StopReload;
            state   <= UART_TX_STOP;
          end else begin
            shifter <= shifter >> 1;
            uart_tx <= shifter[1];
            bit_idx <= bit_idx + 1'b1;
            bit_cnt <= BitReload;
          end
        end
        UART_TX_STOP: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit: frames stay contiguous.
            shifter <= fifo_data;
            uart_tx <= 1'b0;
            bit_cnt <= BitReload;
            state   <= UART_TX_START;
          end else begin
            state <= UART_TX_IDLE;
          end
        end
        default: state <= UART_TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_out_buffered.sv
// Directed bench for uart_out_buffered: three instances cover 1 and 2 stop
// bits at 12 clocks/bit and the rounded 115200-baud period.
module tb_uart_out_buffered;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic       in_valid1 = 1'b0, in_valid2 = 1'b0, in_valid3 = 1'b0;
  logic       in_ready1, in_ready2, in_ready3;
  logic       tx1, tx2, tx3;
  logic       busy1, busy2, busy3;
  logic [2:0] count1, count2, count3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_out_buffered #(.ClockFrequency(12000000), .BaudRate(1000000), .FifoDepth(4), .StopBits(1))
  dut1 (.clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .uart_tx(tx1), .busy(busy1), .fifo_count(count1));

  uart_out_buffered #(.ClockFrequency(12000000), .BaudRate(1000000), .FifoDepth(4), .StopBits(2))
  dut2 (.clock(clock), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .uart_tx(tx2), .busy(busy2), .fifo_count(count2));

  uart_out_buffered #(.ClockFrequency(12000000), .BaudRate(115200), .FifoDepth(4), .StopBits(1))
  dut3 (.clock(clock), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .uart_tx(tx3), .busy(busy3), .fifo_count(count3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      1:       return tx1;
      2:       return tx2;
      default: return tx3;
    endcase
  endfunction

  // Entered on the falling edge just after the push edge N; counts high
  // samples over each bit window so both level and duration are checked.
  task automatic frame_check(input int sel, input logic [7:0] b, input int cnt,
                             input int stops, input string tag);
    logic [9:0] bits;
    int len;
    int ones;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      len  = (i == 9) ? cnt * stops : cnt;
      ones = 0;
      repeat (len) begin
        @(negedge clock);
        ones += int'(tx_of(sel));
      end
      check($sformatf("%s_bit%0d", tag, i), ones, bits[i] ? len : 0);
    end
  endtask

  initial begin
    logic [7:0] burst [6];
    logic [7:0] q [$];
    logic [7:0] got;
    logic [7:0] want;
    int         sent;
    int         guard;
    logic       acc;

    burst = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};

    // Reset state and release
    repeat (3) @(negedge clock);
    check("rst_tx", tx1, 1);
    check("rst_ready", in_ready1, 0);
    check("rst_busy", busy1, 0);
    check("rst_count", count1, 0);
    reset = 1'b0;
    #1 check("rel_ready_low", in_ready1, 0);
    @(negedge clock);
    check("rel_ready_high", in_ready1, 1);
    check("rel_tx", tx1, 1);

    // Single byte 0x55, 12 clocks per bit
    in_data1 = 8'h55; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    check("single_count", count1, 1);
    check("single_tx_idle", tx1, 1);
    check("single_busy", busy1, 1);
    frame_check(1, 8'h55, 12, 1, "single");
    check("single_busy_last", busy1, 1);
    @(negedge clock);
    check("single_busy_fall", busy1, 0);
    check("single_tx_after", tx1, 1);

    // Burst of six with in_valid held high
    fork
      begin
        int i;
        i = 0; guard = 0;
        in_valid1 = 1'b1; in_data1 = burst[0];
        while (i < 6 && guard < 2000) begin
          acc = in_ready1;
          @(negedge clock);
          guard++;
          if (acc) begin
            i++;
            if (i < 6) in_data1 = burst[i];
          end
        end
        in_valid1 = 1'b0;
        check("burst_all_accepted", i, 6);
      end
      begin
        repeat (5) @(negedge clock);
        check("burst_full_count", count1, 4);
        check("burst_full_ready", in_ready1, 0);
      end
      begin
        @(negedge clock);
        for (int k = 0; k < 6; k++) frame_check(1, burst[k], 12, 1, $sformatf("burst%0d", k));
        check("burst_busy_last", busy1, 1);
        @(negedge clock);
        check("burst_busy_fall", busy1, 0);
      end
    join

    // Two stop bits: 0x01 over 132 clocks
    in_data2 = 8'h01; in_valid2 = 1'b1;
    @(negedge clock);
    in_valid2 = 1'b0;
    frame_check(2, 8'h01, 12, 2, "stop2");
    check("stop2_busy_last", busy2, 1);
    @(negedge clock);
    check("stop2_busy_fall", busy2, 0);

    // Rounded period at 115200 baud: 104 clocks per bit
    in_data3 = 8'hC3; in_valid3 = 1'b1;
    @(negedge clock);
    in_valid3 = 1'b0;
    frame_check(3, 8'hC3, 104, 1, "baud115k");
    check("baud115k_busy_last", busy3, 1);
    @(negedge clock);
    check("baud115k_busy_fall", busy3, 0);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    in_data1 = 8'hA5; in_valid1 = 1'b1;
    @(negedge clock);
    in_data1 = 8'h11;
    @(negedge clock);
    in_data1 = 8'h22;
    @(negedge clock);
    in_valid1 = 1'b0;
    repeat (52) @(negedge clock);
    check("midrst_bit3", tx1, 0);
    check("midrst_queued", count1, 2);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx", tx1, 1);
    check("midrst_ready", in_ready1, 0);
    check("midrst_count", count1, 0);
    check("midrst_busy", busy1, 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_rel_busy", busy1, 0);
    check("midrst_rel_count", count1, 0);
    check("midrst_rel_ready", in_ready1, 1);
    in_data1 = 8'h3C; in_valid1 = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    frame_check(1, 8'h3C, 12, 1, "after_rst");
    @(negedge clock);
    check("after_rst_busy_fall", busy1, 0);

    // Backpressure: random valid, data churning while not ready
    sent = 0;
    fork
      begin
        guard = 0;
        while (sent < 32 && guard < 20000) begin
          in_valid1 = 1'($urandom_range(0, 1));
          in_data1  = 8'($urandom);
          if (in_valid1 && in_ready1) begin
            q.push_back(in_data1);
            sent++;
          end
          @(negedge clock);
          guard++;
        end
        in_valid1 = 1'b0;
      end
      begin
        for (int k = 0; k < 32; k++) begin
          int wait_cnt;
          wait_cnt = 0;
          while (tx1 === 1'b1 && wait_cnt < 1000) begin
            @(negedge clock);
            wait_cnt++;
          end
          if (wait_cnt >= 1000) begin
            check("bp_start_timeout", wait_cnt, 0);
            break;
          end
          repeat (6) @(negedge clock);
          for (int j = 0; j < 8; j++) begin
            repeat (12) @(negedge clock);
            got[j] = tx1;
          end
          repeat (12) @(negedge clock);
          check($sformatf("bp_stop%0d", k), tx1, 1);
          want = (q.size() > 0) ? q.pop_front() : ~got;
          check($sformatf("bp_byte%0d", k), got, want);
        end
      end
    join
    check("bp_sent", sent, 32);
    check("bp_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
